// File: rtl/icache_pkg.sv
// icache_pkg: shared icache geometry, refill FSM state encoding and address slicing helpers
package icache_pkg;
  localparam int ADDR = 27;
  localparam int IDX = 12;
  localparam int TAG = 9;
  localparam int OFFSET = 6;
  localparam int DATA_W = 64;
  localparam int BEATS = 8;
  localparam int BEAT_W = $clog2(BEATS);
  typedef enum logic [2:0] {IDLE, REQ_M, FILL_M, COMMIT_M, REQ_A, FILL_A, COMMIT_A} state_t;
  function automatic logic [IDX-1:0] idx_of(input logic [ADDR-1:0] a);
    return a[IDX+OFFSET-1:OFFSET];
  endfunction
  function automatic logic [TAG-1:0] tag_of(input logic [ADDR-1:0] a);
    return a[ADDR-1:IDX+OFFSET];
  endfunction
  function automatic logic [ADDR-1:0] block_of(input logic [ADDR-1:0] a);
    return {a[ADDR-1:OFFSET], OFFSET'(0)};
  endfunction
endpackage

// File: rtl/icache_beat_ctr.sv
// icache_beat_ctr: refill beat counter with clear, enable and last-beat flag
module icache_beat_ctr
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [BEAT_W-1:0] count,
  output logic              last
);
  always_ff @(posedge clk)
    if (rst || clr) count <= '0;
    else if (en) count <= count + 1'b1;
  assign last = count == BEAT_W'(BEATS - 1);
endmodule

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: icache miss FSM; fetches missing block(s) from DRAM, writes data array, commits tags
module icache_refill_ctrl
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR-1:0]   cpu_addr,
  input  logic              missalign,
  input  logic              hit,
  input  logic              hit_missalign,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR-1:0]   mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rerr,
  output logic              data_we,
  output logic [IDX-1:0]    data_index,
  output logic [BEAT_W-1:0] data_beat,
  output logic [DATA_W-1:0] data_wdata,
  output logic              replace_tag,
  output logic              valid_in,
  output logic              replace_tag_align,
  output logic              valid_in_align,
  output logic              fetch_fault
);
  state_t state, state_n;
  logic err_seen;
  logic miss_main, miss_align, fill, beat, last;
  logic [BEAT_W-1:0] count;
  logic [ADDR-1:0] addr_main, addr_align;
  logic [IDX-1:0] index_main, index_align;
  assign miss_main = cpu_req & ~hit;
  assign miss_align = cpu_req & missalign & ~hit_missalign;
  assign addr_main = block_of(cpu_addr);
  assign addr_align = addr_main + ADDR'(1 << OFFSET);
  assign index_main = idx_of(cpu_addr);
  assign index_align = index_main + 1'b1;
  assign fill = state == FILL_M || state == FILL_A;
  assign beat = fill & mem_rvalid;
  icache_beat_ctr u_ctr (
    .clk(clk),
    .rst(rst),
    .clr(~fill),
    .en(beat),
    .count(count),
    .last(last)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = miss_main ? REQ_M : miss_align ? REQ_A : IDLE;
      REQ_M:    state_n = mem_ack ? FILL_M : REQ_M;
      FILL_M:   state_n = beat && last ? COMMIT_M : FILL_M;
      COMMIT_M: state_n = miss_align && !err_seen ? REQ_A : IDLE;
      REQ_A:    state_n = mem_ack ? FILL_A : REQ_A;
      FILL_A:   state_n = beat && last ? COMMIT_A : FILL_A;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      err_seen <= 1'b0;
      data_we <= 1'b0;
      data_index <= '0;
      data_beat <= '0;
      data_wdata <= '0;
    end else begin
      state <= state_n;
      err_seen <= state_n == IDLE ? 1'b0 : err_seen | (beat & mem_rerr);
      data_we <= beat;
      if (beat) begin
        data_index <= state == FILL_A ? index_align : index_main;
        data_beat <= count;
        data_wdata <= mem_rdata;
      end
    end
  assign stall = ~rst & (state != IDLE | miss_main | miss_align);
  assign mem_req = ~rst & (state == REQ_M || state == REQ_A);
  assign mem_addr = state == REQ_A ? addr_align : state == REQ_M ? addr_main : '0;
  assign replace_tag = ~rst & state == COMMIT_M;
  assign valid_in = replace_tag & ~err_seen;
  assign replace_tag_align = ~rst & state == COMMIT_A;
  assign valid_in_align = replace_tag_align & ~err_seen;
  assign fetch_fault = (replace_tag | replace_tag_align) & err_seen;
endmodule
